fetch_stage: RTL and testbench

- Instruction-fetch stage of the LEGv8 pipelined CPU.
- Owns the program counter and drives the byte address into the combinational instruction ROM.
- Captures the returned 32-bit word into the IF/ID pipeline register, with stall, branch redirect/flush and sticky fault handling.
- Sits directly upstream of the instruction ROM and feeds the decode stage.

---
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, ROM address, IF/ID register, sticky fault.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned IMEM_SIZE = 1024,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_stalled
`endif
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic [63:0] ifid_pc_n;
  logic [31:0] ifid_instr_n;
  logic        ifid_valid_n;
  logic        bad_pc;

  // 65-bit sum so a PC near 2^64 cannot wrap past the range check
  assign bad_pc = (pc[1:0] != 2'b00) ||
                  (({1'b0, pc} + 65'd3) >= 65'(IMEM_SIZE));

  assign imem_addr = pc;
  assign fault     = (state == FAULT);

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetched_n, perf_stalled_n;
`endif

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    ifid_pc_n    = ifid_pc;
    ifid_instr_n = ifid_instr;
    ifid_valid_n = ifid_valid;
`ifdef FETCH_PERF_CNT_EN
    perf_fetched_n = perf_fetched;
    perf_stalled_n = perf_stalled;
`endif
    unique case (state)
      RUN: begin
        if (bad_pc) begin
          state_n      = FAULT;
          ifid_valid_n = 1'b0;
          ifid_instr_n = NOP_INSTR;
        end else if (br_taken) begin
          pc_n         = br_target;
          ifid_valid_n = 1'b0;
          ifid_instr_n = NOP_INSTR;
        end else if (stall) begin
`ifdef FETCH_PERF_CNT_EN
          perf_stalled_n = perf_stalled + 64'd1;
`endif
        end else begin
          ifid_pc_n    = pc;
          ifid_instr_n = imem_instr;
          ifid_valid_n = 1'b1;
          pc_n         = pc + 64'd4;
`ifdef FETCH_PERF_CNT_EN
          perf_fetched_n = perf_fetched + 64'd1;
`endif
        end
      end
      FAULT: begin
        ifid_valid_n = 1'b0;
        ifid_instr_n = NOP_INSTR;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      pc         <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      perf_fetched <= '0;
      perf_stalled <= '0;
`endif
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      ifid_pc    <= ifid_pc_n;
      ifid_instr <= ifid_instr_n;
      ifid_valid <= ifid_valid_n;
`ifdef FETCH_PERF_CNT_EN
      perf_fetched <= perf_fetched_n;
      perf_stalled <= perf_stalled_n;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed cycles push expected state, a monitor checks it.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken;
  logic [63:0] br_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        fault;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetched, perf_stalled;
`endif

  always #5 clk = ~clk;

  // ROM model: word at byte address A is {16'hCAFE, A[15:0]}
  assign imem_instr = {16'hCAFE, imem_addr[15:0]};

  fetch_stage #(
    .RESET_PC (64'd0),
    .IMEM_SIZE(1024),
    .NOP_INSTR(NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem_addr (imem_addr),
    .imem_instr(imem_instr),
    .ifid_pc   (ifid_pc),
    .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid),
    .fault     (fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stalled(perf_stalled)
`endif
  );

  always @(posedge clk)
    if (!reset)
      assert (!$isunknown({stall, br_taken, br_target, imem_instr}))
        else $error("X on fetch_stage input");

  typedef struct {
    int          row;
    logic [63:0] addr;
    logic        v;
    logic [63:0] ipc;
    logic [31:0] instr;
    logic        f;
    logic [63:0] pf;
    logic [63:0] ps;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL row%0d %s actual=%h required=%h", row, name, act, req);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("imem_addr",  e.row, imem_addr, e.addr);
      chk("ifid_valid", e.row, 64'(ifid_valid), 64'(e.v));
      chk("ifid_pc",    e.row, ifid_pc, e.ipc);
      chk("ifid_instr", e.row, 64'(ifid_instr), 64'(e.instr));
      chk("fault",      e.row, 64'(fault), 64'(e.f));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", e.row, perf_fetched, e.pf);
      chk("perf_stalled", e.row, perf_stalled, e.ps);
`endif
    end
  end

  int row_n = 0;

  task automatic cyc(input logic r, input logic s, input logic b, input logic [63:0] t,
                     input logic [63:0] addr, input logic v, input logic [63:0] ipc,
                     input logic [31:0] instr, input logic f,
                     input logic [63:0] pf, input logic [63:0] ps);
    exp_t e;
    reset = r; stall = s; br_taken = b; br_target = t;
    row_n++;
    e.row = row_n; e.addr = addr; e.v = v; e.ipc = ipc; e.instr = instr;
    e.f = f; e.pf = pf; e.ps = ps;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int wait_cyc;
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    //  rst stall br target        addr      v  ifid_pc   instr         f  pf ps
    cyc(1, 0, 0, 64'h0,   64'h0,   0, 64'h0,   NOP,          0, 0, 0);
    cyc(1, 0, 0, 64'h0,   64'h0,   0, 64'h0,   NOP,          0, 0, 0);
    cyc(0, 0, 0, 64'h0,   64'h4,   1, 64'h0,   32'hCAFE0000, 0, 1, 0);
    cyc(0, 0, 0, 64'h0,   64'h8,   1, 64'h4,   32'hCAFE0004, 0, 2, 0);
    cyc(0, 1, 0, 64'h0,   64'h8,   1, 64'h4,   32'hCAFE0004, 0, 2, 1);
    cyc(0, 1, 0, 64'h0,   64'h8,   1, 64'h4,   32'hCAFE0004, 0, 2, 2);
    cyc(0, 0, 0, 64'h0,   64'hC,   1, 64'h8,   32'hCAFE0008, 0, 3, 2);
    cyc(0, 0, 0, 64'h0,   64'h10,  1, 64'hC,   32'hCAFE000C, 0, 4, 2);
    cyc(0, 1, 1, 64'h40,  64'h40,  0, 64'hC,   NOP,          0, 4, 2);
    cyc(0, 0, 0, 64'h0,   64'h44,  1, 64'h40,  32'hCAFE0040, 0, 5, 2);
    cyc(0, 0, 1, 64'h42,  64'h42,  0, 64'h40,  NOP,          0, 5, 2);
    cyc(0, 0, 0, 64'h0,   64'h42,  0, 64'h40,  NOP,          1, 5, 2);
    for (int unsigned i = 0; i < 10; i++)
      cyc(0, i[0], i[1], 64'h100, 64'h42, 0, 64'h40, NOP, 1, 5, 2);
    cyc(1, 1, 1, 64'h100, 64'h0,   0, 64'h0,   NOP,          0, 0, 0);
    cyc(0, 0, 1, 64'h3F8, 64'h3F8, 0, 64'h0,   NOP,          0, 0, 0);
    cyc(0, 0, 0, 64'h0,   64'h3FC, 1, 64'h3F8, 32'hCAFE03F8, 0, 1, 0);
    cyc(0, 0, 0, 64'h0,   64'h400, 1, 64'h3FC, 32'hCAFE03FC, 0, 2, 0);
    cyc(0, 0, 0, 64'h0,   64'h400, 0, 64'h3FC, NOP,          1, 2, 0);
    cyc(1, 1, 0, 64'h0,   64'h0,   0, 64'h0,   NOP,          0, 0, 0);
    cyc(0, 0, 0, 64'h0,   64'h4,   1, 64'h0,   32'hCAFE0000, 0, 1, 0);
    cyc(0, 1, 0, 64'h0,   64'h4,   1, 64'h0,   32'hCAFE0000, 0, 1, 1);
    cyc(1, 1, 0, 64'h0,   64'h0,   0, 64'h0,   NOP,          0, 0, 0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    #1;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain pending=%0d required=0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
